// File: rtl/frame_bbox.sv
// frame_bbox: classifies each pixel of the cropped stream as foreground when its
// L1 colour distance from the fill colour exceeds THRESH, accumulates the
// foreground bounding box and pixel count over a frame, and latches the result
// with a one-cycle done pulse at end of frame.
module frame_bbox #(
    parameter int P_W    = 11,
    parameter int C_W    = 8,
    parameter int IMG_X  = 640,
    parameter int IMG_Y  = 480,
    parameter int BG_R   = 0,
    parameter int BG_G   = 0,
    parameter int BG_B   = 0,
    parameter int THRESH = 24
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             i_valid,
    input  logic [C_W-1:0]   i_R,
    input  logic [C_W-1:0]   i_G,
    input  logic [C_W-1:0]   i_B,
    output logic             o_done,
    output logic             o_found,
    output logic [P_W-1:0]   o_x_min,
    output logic [P_W-1:0]   o_x_max,
    output logic [P_W-1:0]   o_y_min,
    output logic [P_W-1:0]   o_y_max,
    output logic [2*P_W-1:0] o_count
);

    localparam logic [P_W-1:0]   X_LAST   = P_W'(IMG_X - 1);
    localparam logic [P_W-1:0]   Y_LAST   = P_W'(IMG_Y - 1);
    localparam logic [C_W-1:0]   BG_R_C   = C_W'(BG_R);
    localparam logic [C_W-1:0]   BG_G_C   = C_W'(BG_G);
    localparam logic [C_W-1:0]   BG_B_C   = C_W'(BG_B);
    localparam logic [C_W+1:0]   THRESH_C = (C_W+2)'(THRESH);

    function automatic logic [C_W+1:0] abs_diff(input logic [C_W-1:0] a, input logic [C_W-1:0] b);
        return (a >= b) ? {2'b00, a - b} : {2'b00, b - a};
    endfunction

    // stage 0: raster position of the incoming beat
    logic [P_W-1:0] cnt_x_q, cnt_y_q;
    // stage 1: registered classification of that beat
    logic           v1_q, fg1_q, last1_q;
    logic [P_W-1:0] x1_q, y1_q;
    // stage 2: running frame accumulators
    logic [P_W-1:0]   x_min_q, x_max_q, y_min_q, y_max_q;
    logic [2*P_W-1:0] cnt_q;
    logic [P_W-1:0]   x_min_d, x_max_d, y_min_d, y_max_d;
    logic [2*P_W-1:0] cnt_d;
    // latched results
    logic             done_q, found_q;
    logic [P_W-1:0]   ox_min_q, ox_max_q, oy_min_q, oy_max_q;
    logic [2*P_W-1:0] ocnt_q;

    logic [C_W+1:0] dist_d;
    logic           fg_d;
    logic           hit;
    logic           eof;

    // Three channels of at most 2^C_W-1 each fit in C_W+2 bits without overflow.
    assign dist_d = abs_diff(i_R, BG_R_C) + abs_diff(i_G, BG_G_C) + abs_diff(i_B, BG_B_C);
    assign fg_d   = (dist_d > THRESH_C);

    // Position counters advance only on valid beats, wrapping x then y.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_x_q <= '0;
            cnt_y_q <= '0;
        end else if (i_valid) begin
            if (cnt_x_q == X_LAST) begin
                cnt_x_q <= '0;
                cnt_y_q <= (cnt_y_q == Y_LAST) ? '0 : cnt_y_q + P_W'(1);
            end else begin
                cnt_x_q <= cnt_x_q + P_W'(1);
            end
        end
    end

    // Stage 1 captures position and classification; v1 marks a live beat each cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            v1_q    <= 1'b0;
            fg1_q   <= 1'b0;
            last1_q <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
        end else begin
            v1_q <= i_valid;
            if (i_valid) begin
                fg1_q   <= fg_d;
                last1_q <= (cnt_x_q == X_LAST) && (cnt_y_q == Y_LAST);
                x1_q    <= cnt_x_q;
                y1_q    <= cnt_y_q;
            end
        end
    end

    assign hit = v1_q && fg1_q;
    assign eof = v1_q && last1_q;

    // Accumulator values including the pixel in stage 1, so the last pixel counts.
    always_comb begin
        x_min_d = x_min_q;
        x_max_d = x_max_q;
        y_min_d = y_min_q;
        y_max_d = y_max_q;
        cnt_d   = cnt_q;
        if (hit) begin
            if (x1_q < x_min_q) x_min_d = x1_q;
            if (x1_q > x_max_q) x_max_d = x1_q;
            if (y1_q < y_min_q) y_min_d = y1_q;
            if (y1_q > y_max_q) y_max_d = y1_q;
            if (cnt_q != '1)    cnt_d   = cnt_q + (2*P_W)'(1);
        end
    end

    // Accumulators update per live beat and return to idle at end of frame.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst || (!sys_rst && eof)) begin
            x_min_q <= '1;
            x_max_q <= '0;
            y_min_q <= '1;
            y_max_q <= '0;
            cnt_q   <= '0;
        end else if (v1_q) begin
            x_min_q <= x_min_d;
            x_max_q <= x_max_d;
            y_min_q <= y_min_d;
            y_max_q <= y_max_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers load at end of frame and hold until the next one.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            ox_min_q <= '0;
            ox_max_q <= '0;
            oy_min_q <= '0;
            oy_max_q <= '0;
            ocnt_q   <= '0;
        end else begin
            done_q <= eof;
            if (eof) begin
                found_q <= (cnt_d != '0);
                if (cnt_d != '0) begin
                    ox_min_q <= x_min_d;
                    ox_max_q <= x_max_d;
                    oy_min_q <= y_min_d;
                    oy_max_q <= y_max_d;
                    ocnt_q   <= cnt_d;
                end else begin
                    ox_min_q <= '0;
                    ox_max_q <= '0;
                    oy_min_q <= '0;
                    oy_max_q <= '0;
                    ocnt_q   <= '0;
                end
            end
        end
    end

    assign o_done  = done_q;
    assign o_found = found_q;
    assign o_x_min = ox_min_q;
    assign o_x_max = ox_max_q;
    assign o_y_min = oy_min_q;
    assign o_y_max = oy_max_q;
    assign o_count = ocnt_q;

endmodule
